xor_stream_accum: RTL
=====================

// Module: xor_stream_accum
// PURPOSE
//  Parametrised, registered successor to the 2-input XOR gate.
//  - Folds a stream of WIDTH-bit words into one XOR word per frame, plus a parity bit and a beat count.
//  - Valid/ready handshake on both the input and the output side.
//  - Sits between a packet source and a checker; used for frame parity/checksum generation.
// PARAMETERS
//  WIDTH  8  data word width (>=1)
//  CNT_W  8  beat counter width; the count saturates at 2**CNT_W-1
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      input beat valid
//  in_ready    out  1      block can accept an input beat
//  in_data     in   WIDTH  input word
//  in_last     in   1      final beat of the frame (qualified by in_valid)
//  out_valid   out  1      frame result valid
//  out_ready   in   1      downstream accepts the result
//  out_word    out  WIDTH  XOR of all words in the frame
//  out_parity  out  1      ^out_word (even parity of the whole frame)
//  out_count   out  CNT_W  number of beats in the frame, saturating
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset values:
//    - in_ready=1
//    - out_valid=0, out_word=0, out_parity=0, out_count=0
//    - internal acc=0, cnt=0, state=IDLE
//  - Beat accept = in_valid & in_ready. Result transfer = out_valid & out_ready.
//  - States:
//    - IDLE: no frame open.
//    - ACC: frame open, at least one beat taken, no last yet.
//    - DONE: result held.
//  - IDLE, accept without last: acc<=in_data, cnt<=1, go to ACC.
//  - IDLE, accept with last (1-beat frame): result = in_data, count 1, go to DONE.
//  - ACC, accept without last: acc<=acc^in_data, cnt<=sat(cnt+1).
//  - ACC, accept with last: out_word<=acc^in_data, out_count<=sat(cnt+1), go to DONE.
//  - ACC with in_valid=0: hold all state. Idle gaps inside a frame are legal.
//  - On entry to DONE:
//    - out_valid<=1; out_parity = XOR-reduce of the new out_word.
//    - Latency from the last-beat accept edge to out_valid=1 is 1 cycle.
//  - DONE: in_ready=0. out_word, out_parity and out_count stay stable until transfer.
//  - DONE on transfer: out_valid<=0, acc<=0, cnt<=0, go to IDLE.
//  - in_ready = (state!=DONE) in the base build.
//  - Counter saturation: cnt stops at 2**CNT_W-1. XOR folding continues past saturation.
//  - out_* are registered. No combinational path from in_* to out_*.
//  - in_ready depends only on state in the base build.
//  - Asserting rst_n low mid-frame or in DONE drops the frame at once. All outputs go to their reset values.
// CONFIGURATION
//  - XOR_STREAM_BACK2BACK_EN defined:
//    - in_ready = (state!=DONE) | out_ready.
//    - In DONE with transfer and a same-cycle beat accept, the beat opens the next frame.
//    - That next-frame beat goes to IDLE-entry rules, so the next state is ACC, or DONE for a 1-beat frame.
//    - Sustains one beat per cycle across frame boundaries.
//  - Undefined:
//    - The base rule above applies.
//    - At least one bubble cycle follows every frame.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out_word=0, out_count=0, in_ready=1.
//  - XOR truth table as 1-bit frames (WIDTH=1): frames {0,0} {1,0} {0,1} {1,1} ->
//    - out_word 0,1,1,0
//    - out_parity 0,1,1,0
//    - out_count 2 each
//  - Frame 8'h0F, 8'hF0, 8'hFF(last) -> out_word=8'h00, out_parity=0, out_count=3.
//    - out_valid is high 1 cycle after the last beat.
//  - Backpressure: after a frame completes, hold out_ready=0 for 5 cycles ->
//    - out_valid=1, out_word stable, in_ready=0
//    - a beat offered during the stall is not accepted
//  - Saturation (CNT_W=2): 6-beat frame of 8'h01 -> out_count=3, out_word=8'h00.
//  - Mid-frame reset after 2 beats, then frame 8'hA5(last) -> out_word=8'hA5, out_count=1.
//  - XOR_STREAM_BACK2BACK_EN: two 1-beat frames 8'h3C then 8'hC3 on consecutive cycles, out_ready=1 ->
//    - results 8'h3C then 8'hC3 on consecutive cycles
//    - no bubble

Source files
------------

// File: rtl/xor_stream_accum.sv
// Streaming XOR accumulator: folds a frame of words into one XOR word, parity bit and saturating beat count.
// Optional XOR_STREAM_BACK2BACK_EN lets a new frame open in the same cycle the previous result is taken.
module xor_stream_accum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  logic             beat_acc;
  logic             xfer;
  logic             open_frame;
  logic [WIDTH-1:0] acc_x;
  logic [CNT_W-1:0] cnt_inc;

`ifdef XOR_STREAM_BACK2BACK_EN
  assign in_ready = (state_q != DONE) | out_ready;
`else
  assign in_ready = (state_q != DONE);
`endif

  assign beat_acc = in_valid & in_ready;
  assign xfer     = valid_q & out_ready;
  assign acc_x    = acc_q ^ in_data;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // A beat in DONE can only be accepted alongside a transfer, so it opens a frame exactly like IDLE.
  assign open_frame = beat_acc & ((state_q == IDLE) | ((state_q == DONE) & xfer));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    parity_d = parity_q;
    count_d  = count_q;
    valid_d  = valid_q;

    case (state_q)
      ACC: begin
        if (beat_acc) begin
          acc_d = acc_x;
          cnt_d = cnt_inc;
          if (in_last) begin
            word_d   = acc_x;
            parity_d = ^acc_x;
            count_d  = cnt_inc;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (xfer) begin
          valid_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (open_frame) begin
      if (in_last) begin
        word_d   = in_data;
        parity_d = ^in_data;
        count_d  = CNT_W'(1);
        valid_d  = 1'b1;
        state_d  = DONE;
      end else begin
        acc_d   = in_data;
        cnt_d   = CNT_W'(1);
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      parity_q <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      parity_q <= parity_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_word   = word_q;
  assign out_parity = parity_q;
  assign out_count  = count_q;

endmodule
